seq_detector_param: RTL and testbench

//  - Parametrised serial bit-pattern detector; successor to fixed 4-bit "1101" detector.
//  - Shifts a qualified serial bit stream into a PAT_W-deep history register and

---
 rtl/seq_detector_param_if.sv | 37 +++
 rtl/seq_detector_param.sv | 80 ++++++++
 tb/tb_seq_detector_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: qualified bit stream in, match status out.
// master drives the stream and control, slave is the detector.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             overlap_en;
    logic             clear;
    logic             match;
    logic             found;
    logic [CNT_W-1:0] match_count;
    logic [PAT_W-1:0] hist;

    modport master (
        output in_valid,
        output in_bit,
        output overlap_en,
        output clear,
        input  match,
        input  found,
        input  match_count,
        input  hist
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  overlap_en,
        input  clear,
        output match,
        output found,
        output match_count,
        output hist
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with overlap control.
// SEQ_DET_CNT_WRAP_EN: match_count wraps instead of saturating.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] shifted;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    assign shifted = {hist_q[PAT_W-2:0], bus.in_bit};
    assign hit     = (shifted == PATTERN) && (fill_q >= FW'(PAT_W - 1));

`ifdef SEQ_DET_CNT_WRAP_EN
    assign cnt_inc = cnt_q + CNT_W'(1);
`else
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`endif

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        found_d = found_q;
        cnt_d   = cnt_q;
        if (bus.clear) begin
            hist_d  = '0;
            fill_d  = '0;
            found_d = 1'b0;
            cnt_d   = '0;
        end else if (bus.in_valid) begin
            hist_d  = shifted;
            match_d = hit;
            // a non-overlapping hit forces the next match to use fresh bits only
            if (hit && !bus.overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FW'(PAT_W)) begin
                fill_d = fill_q + FW'(1);
            end
            if (hit) begin
                found_d = 1'b1;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            found_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            found_q <= found_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.found       = found_q;
    assign bus.match_count = cnt_q;
    assign bus.hist        = hist_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random stream
// checked against a queue-based reference model.
module tb_seq_detector_param;
    localparam int              PW  = 4;
    localparam logic [PW-1:0]   PAT = 4'b1101;
    localparam int              CW  = 2;
    localparam int              CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;

    seq_detector_param_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    seq_detector_param #(
        .PAT_W  (PW),
        .PATTERN(PAT),
        .CNT_W  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int bits[$];
    int fresh;
    int m_match;
    int m_found;
    int m_cnt;

    function automatic int m_hist();
        int h = 0;
        foreach (bits[i]) h = h * 2 + bits[i];
        return h;
    endfunction

    task automatic m_reset();
        bits.delete();
        fresh   = 0;
        m_match = 0;
        m_found = 0;
        m_cnt   = 0;
    endtask

    task automatic m_edge(input bit v, input bit b, input bit ov, input bit clr);
        if (clr) begin
            m_reset();
        end else if (v) begin
            bits.push_back(int'(b));
            if (bits.size() > PW) void'(bits.pop_front());
            fresh++;
            m_match = (fresh >= PW && m_hist() == int'(PAT)) ? 1 : 0;
            if (m_match == 1) begin
                m_found = 1;
`ifdef SEQ_DET_CNT_WRAP_EN
                m_cnt = (m_cnt + 1) % (CMAX + 1);
`else
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
`endif
                if (!ov) fresh = 0;
            end
        end else begin
            m_match = 0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("match", int'(bus.match), m_match);
        chk("found", int'(bus.found), m_found);
        chk("count", int'(bus.match_count), m_cnt);
        chk("hist", int'(bus.hist), m_hist());
    endtask

    task automatic step(input bit v, input bit b, input bit ov, input bit clr);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_bit     = b;
        bus.overlap_en = ov;
        bus.clear      = clr;
        @(posedge clk);
        m_edge(v, b, ov, clr);
        #1;
        check_all();
    endtask

    task automatic feed(input int n, input logic [31:0] pat, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, pat[i], ov, 1'b0);
    endtask

    task automatic areset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_all();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.overlap_en = 1'b1;
        bus.clear      = 1'b0;
        reset          = 1'b1;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // basic detection
        feed(4, 32'b1101, 1'b1);
        chk("t1_match", int'(bus.match), 1);
        chk("t1_hist", int'(bus.hist), 'b1101);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pulse_end", int'(bus.match), 0);

        // overlapping
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed(7, 32'b1101101, 1'b1);
        chk("t2_count", int'(bus.match_count), 2);

        // non-overlapping then fresh bits
        step(1'b0, 1'b0, 1'b0, 1'b1);
        feed(7, 32'b1101101, 1'b0);
        chk("t3_count", int'(bus.match_count), 1);
        feed(4, 32'b1101, 1'b0);
        chk("t3_count2", int'(bus.match_count), 2);

        // gaps then clear with a completing bit
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_found", int'(bus.found), 0);
        chk("t4_hist", int'(bus.hist), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_nomatch", int'(bus.match), 0);

        // counter saturation / wrap with 4 hits
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed(13, 32'b1101101101101, 1'b1);
`ifdef SEQ_DET_CNT_WRAP_EN
        chk("t5_count", int'(bus.match_count), 0);
`else
        chk("t5_count", int'(bus.match_count), 3);
`endif
        chk("t5_found", int'(bus.found), 1);

        // async reset mid-sequence
        feed(3, 32'b110, 1'b1);
        areset();
        chk("t6_hist", int'(bus.hist), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_nomatch", int'(bus.match), 0);

        // randomized stream
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                areset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
